// File: rtl/result_demux_6_pkg.sv
// Shared constants and types for the six-way result dispatcher.
// Destination codes below DEST_INVALID select a consumer port; the rest are dropped.
package result_demux_6_pkg;

  localparam int NUM_DEST = 6;
  localparam int DEST_W   = 3;

  localparam logic [DEST_W-1:0] DEST_0       = 3'd0;
  localparam logic [DEST_W-1:0] DEST_1       = 3'd1;
  localparam logic [DEST_W-1:0] DEST_2       = 3'd2;
  localparam logic [DEST_W-1:0] DEST_3       = 3'd3;
  localparam logic [DEST_W-1:0] DEST_4       = 3'd4;
  localparam logic [DEST_W-1:0] DEST_5       = 3'd5;
  localparam logic [DEST_W-1:0] DEST_INVALID = 3'd6;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic dest_is_valid(input logic [DEST_W-1:0] dest);
    return dest < DEST_INVALID;
  endfunction

endpackage

// File: rtl/result_demux_6_if.sv
// Producer/consumer bundle of the result dispatcher; slave = dispatcher, master = environment.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
interface result_demux_6_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  import result_demux_6_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [DEST_W-1:0]   in_dest;
  logic [NUM_DEST-1:0] out_valid;
  logic [NUM_DEST-1:0] out_ready;
  logic [DATA_W-1:0]   out_data_0;
  logic [DATA_W-1:0]   out_data_1;
  logic [DATA_W-1:0]   out_data_2;
  logic [DATA_W-1:0]   out_data_3;
  logic [DATA_W-1:0]   out_data_4;
  logic [DATA_W-1:0]   out_data_5;
  logic                err;
  logic                clr_err;
  logic [CNT_W-1:0]    drop_count;
  slot_state_t         slot_state [NUM_DEST];

  modport slave (
    input  in_valid, in_data, in_dest, out_ready, clr_err,
    output in_ready, out_valid, err, drop_count, slot_state,
    output out_data_0, out_data_1, out_data_2, out_data_3, out_data_4, out_data_5
  );

  modport master (
    output in_valid, in_data, in_dest, out_ready, clr_err,
    input  in_ready, out_valid, err, drop_count, slot_state,
    input  out_data_0, out_data_1, out_data_2, out_data_3, out_data_4, out_data_5
  );

endinterface

// File: rtl/result_demux_6_dispatch_slot.sv
// One-entry holding register for a single consumer port, with EMPTY/FULL state exposed.
// A write while FULL is only issued by the top when the consumer drains in the same cycle.
module dispatch_slot
  import result_demux_6_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output slot_state_t       state
);

  slot_state_t       state_q;
  slot_state_t       state_d;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (wr_en) state_d = SLOT_FULL;
      // A same-cycle refill keeps the slot FULL with no bubble.
      SLOT_FULL:  if (rd_ready && !wr_en) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_q == SLOT_FULL);
    state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (wr_en) begin
      data_q <= wr_data;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/result_demux_6.sv
// Six-way result dispatcher: routes one tagged result per cycle into per-port holding slots,
// dropping out-of-range codes and recording them in a sticky flag and saturating counter.
module result_demux_6
  import result_demux_6_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  result_demux_6_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_DEST-1:0] valid_q;
  logic [NUM_DEST-1:0] wr_en;
  logic [DATA_W-1:0]   data_q [NUM_DEST];
  slot_state_t         st_q   [NUM_DEST];
  logic                in_ready_c;
  logic                accept;
  logic                drop;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  // Invalid codes are always accepted; a reset cycle reads as all slots empty.
  always_comb begin
    in_ready_c = 1'b1;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (bus.in_dest == DEST_W'(k)) begin
        in_ready_c = !valid_q[k] || bus.out_ready[k];
      end
    end
    if (rst) begin
      in_ready_c = 1'b1;
    end
  end

  assign accept = bus.in_valid && in_ready_c;
  assign drop   = accept && !dest_is_valid(bus.in_dest);

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      wr_en[k] = accept && (bus.in_dest == DEST_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_slot
    dispatch_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[g]),
      .wr_data  (bus.in_data),
      .rd_ready (bus.out_ready[g]),
      .valid    (valid_q[g]),
      .data     (data_q[g]),
      .state    (st_q[g])
    );
  end

  // Clear has priority over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_err) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (drop) begin
      err_q <= 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = valid_q;
  assign bus.out_data_0 = data_q[0];
  assign bus.out_data_1 = data_q[1];
  assign bus.out_data_2 = data_q[2];
  assign bus.out_data_3 = data_q[3];
  assign bus.out_data_4 = data_q[4];
  assign bus.out_data_5 = data_q[5];
  assign bus.err        = err_q;
  assign bus.drop_count = cnt_q;
  assign bus.slot_state = st_q;

endmodule

// File: tb/tb_result_demux_6.sv
// Bench for result_demux_6: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the six one-entry slots.
module tb_result_demux_6;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int ND = 6;

  logic clk;
  logic rst;

  result_demux_6_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  result_demux_6 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [ND][$];
  logic [DW-1:0] last_data [ND];
  logic          m_err;
  int            m_cnt;
  logic          m_live = 1'b0;
  logic [DW-1:0] dout [ND];

  assign dout[0] = bus.out_data_0;
  assign dout[1] = bus.out_data_1;
  assign dout[2] = bus.out_data_2;
  assign dout[3] = bus.out_data_3;
  assign dout[4] = bus.out_data_4;
  assign dout[5] = bus.out_data_5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    int d;
    d = int'(bus.in_dest);
    if (rst) return 1'b1;
    if (d >= ND) return 1'b1;
    return (exp_q[d].size() == 0) || bus.out_ready[d];
  endfunction

  function automatic logic [ND-1:0] model_valid();
    logic [ND-1:0] v;
    for (int k = 0; k < ND; k++) v[k] = (exp_q[k].size() != 0);
    return v;
  endfunction

  // Model: drain every slot whose consumer is ready, then place the accepted result.
  always @(posedge clk) begin
    logic rdy;
    logic drop_m;
    int   d;
    if (rst) begin
      for (int k = 0; k < ND; k++) begin
        exp_q[k].delete();
        last_data[k] = '0;
      end
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      d      = int'(bus.in_dest);
      rdy    = model_ready();
      drop_m = 1'b0;
      for (int k = 0; k < ND; k++) begin
        if (exp_q[k].size() != 0 && bus.out_ready[k]) void'(exp_q[k].pop_front());
      end
      if (bus.in_valid && rdy) begin
        if (d < ND) begin
          exp_q[d].push_back(bus.in_data);
          last_data[d] = bus.in_data;
        end else begin
          drop_m = 1'b1;
        end
      end
      if (bus.clr_err) begin
        m_err = 1'b0;
        m_cnt = 0;
      end else if (drop_m) begin
        m_err = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
    m_live = 1'b1;
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
      check("out_valid", 32'(bus.out_valid), 32'(model_valid()));
      for (int k = 0; k < ND; k++) begin
        check($sformatf("out_data_%0d", k), dout[k], last_data[k]);
        if (exp_q[k].size() > 1) check($sformatf("model_depth_%0d", k), 32'(exp_q[k].size()), 32'd1);
      end
      check("err", 32'(bus.err), 32'(m_err));
      check("drop_count", 32'(bus.drop_count), 32'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] dest, input logic [DW-1:0] data);
    bus.in_valid = v;
    bus.in_dest  = dest;
    bus.in_data  = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.out_ready = 6'h3f;
    bus.clr_err   = 1'b0;
    set_in(1'b1, 3'd0, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data_0", bus.out_data_0, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    step();
    rst = 1'b0;
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // single result to port 2, drained next cycle
    set_in(1'b1, 3'd2, 32'h1234_5678);
    @(negedge clk);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t1_out_valid", 32'(bus.out_valid), 32'h04);
    check("t1_out_data_2", bus.out_data_2, 32'h1234_5678);
    step();
    @(negedge clk);
    check("t1_drained", 32'(bus.out_valid), 32'd0);

    // stalled port 4, then pass-through refill
    bus.out_ready = 6'h2f;
    set_in(1'b1, 3'd4, 32'hAAAA_0001);
    step();
    set_in(1'b1, 3'd4, 32'hAAAA_0002);
    @(negedge clk);
    check("t2_refused", 32'(bus.in_ready), 32'd0);
    check("t2_hold", bus.out_data_4, 32'hAAAA_0001);
    step();
    @(negedge clk);
    check("t2_hold2", bus.out_data_4, 32'hAAAA_0001);
    bus.out_ready = 6'h3f;
    @(negedge clk);
    check("t2_ready_on_drain", 32'(bus.in_ready), 32'd1);
    step();
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t2_refill_valid", 32'(bus.out_valid), 32'h10);
    check("t2_refill_data", bus.out_data_4, 32'hAAAA_0002);
    step();

    // stalled port 1 does not block port 3
    bus.out_ready = 6'h00;
    set_in(1'b1, 3'd1, 32'h0000_1111);
    step();
    set_in(1'b1, 3'd3, 32'h0000_BEEF);
    @(negedge clk);
    check("t3_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t3_out_valid", 32'(bus.out_valid), 32'h0A);
    check("t3_out_data_3", bus.out_data_3, 32'h0000_BEEF);
    bus.out_ready = 6'h3f;
    step();

    // invalid code 7 three times, then clear
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 3'd7, $urandom);
      @(negedge clk);
      check("t4_in_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t4_out_valid", 32'(bus.out_valid), 32'd0);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_drop_count", 32'(bus.drop_count), 32'd3);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    @(negedge clk);
    check("t4_clr_err", 32'(bus.err), 32'd0);
    check("t4_clr_count", 32'(bus.drop_count), 32'd0);

    // saturation with code 6, then clear winning over a drop
    for (int i = 0; i < 256; i++) begin
      set_in(1'b1, 3'd6, $urandom);
      step();
    end
    @(negedge clk);
    check("t5_saturate", 32'(bus.drop_count), 32'd255);
    check("t5_err", 32'(bus.err), 32'd1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t5_clr_wins_cnt", 32'(bus.drop_count), 32'd0);
    check("t5_clr_wins_err", 32'(bus.err), 32'd0);

    // mid-operation reset discards held results
    bus.out_ready = 6'h00;
    set_in(1'b1, 3'd0, 32'h0000_00A0);
    step();
    set_in(1'b1, 3'd5, 32'h0000_00A5);
    step();
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t6_filled", 32'(bus.out_valid), 32'h21);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_data_0", bus.out_data_0, 32'd0);
    check("t6_rst_data_5", bus.out_data_5, 32'd0);
    check("t6_rst_err", 32'(bus.err), 32'd0);
    bus.out_ready = 6'h3f;
    set_in(1'b1, 3'd0, 32'h0000_00C0);
    step();
    set_in(1'b0, 3'd0, '0);
    @(negedge clk);
    check("t6_fresh_valid", 32'(bus.out_valid), 32'h01);
    check("t6_fresh_data", bus.out_data_0, 32'h0000_00C0);
    step();

    // randomized traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom);
      for (int k = 0; k < ND; k++) bus.out_ready[k] = ($urandom_range(0, 9) < 6);
      bus.clr_err = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst         = 1'b0;
    bus.clr_err = 1'b0;
    set_in(1'b0, 3'd0, '0);
    bus.out_ready = 6'h3f;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
